// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, NOP word and reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] MIPS_NOP             = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads one instruction per PC over an Avalon-MM read master and hands {instr, pc}
// to decode. Optional misaligned-PC trap is built when IFETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              redirect,
    output logic              fetch_stall,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err,
    output fetch_state_t      state_dbg
);

    // Decode handshake: an instruction transfers on a rising edge where instr_valid && instr_ready
    // and redirect is low; while instr_valid is high, instr_out/instr_pc/fetch_err do not change.

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_d, ipc_d;
    logic [DATA_W-1:0] iout_d;
    logic              read_d, ival_d, err_d;
    logic              do_issue;
    logic              misaligned;
    logic [ADDR_W-1:0] aligned_pc;

    assign aligned_pc = {pc_in[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_in[1:0];
    assign misaligned    = 1'b0;
`endif

    assign fetch_stall = (state_q != IDLE);
    assign state_dbg   = state_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = avm_address;
        read_d   = avm_read;
        iout_d   = instr_out;
        ipc_d    = instr_pc;
        ival_d   = instr_valid;
        err_d    = fetch_err;
        do_issue = 1'b0;

        case (state_q)
            IDLE: begin
                // A redirect here needs no action: the PC already presents the new target.
                do_issue = pc_valid;
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    read_d = 1'b0;
                    if (redirect) begin
                        state_d = IDLE;
                    end else begin
                        iout_d  = avm_readdata;
                        ipc_d   = avm_address;
                        ival_d  = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The bus read cannot be withdrawn; wait it out and throw the word away.
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (redirect) begin
                    ival_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (instr_ready) begin
                    ival_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                    do_issue = pc_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_issue) begin
            if (misaligned) begin
                iout_d  = DATA_W'(MIPS_NOP);
                ipc_d   = pc_in;
                ival_d  = 1'b1;
                err_d   = 1'b1;
                state_d = HOLD;
            end else begin
                addr_d  = aligned_pc;
                read_d  = 1'b1;
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            avm_address <= RESET_VECTOR;
            avm_read    <= 1'b0;
            instr_out   <= DATA_W'(MIPS_NOP);
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            avm_address <= addr_d;
            avm_read    <= read_d;
            instr_out   <= iout_d;
            instr_pc    <= ipc_d;
            instr_valid <= ival_d;
            fetch_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized fetch transactions against a memory model and scoreboard.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int W = 65;  // {fetch_err, instr_pc, instr_out}

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc_in;
    logic         pc_valid;
    logic         redirect;
    logic         fetch_stall;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic [31:0]  instr_out;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         fetch_err;
    fetch_state_t state_dbg;

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   exp_item;
    bit             chained = 1'b0;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_valid        (pc_valid),
        .redirect        (redirect),
        .fetch_stall     (fetch_stall),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fetch_err       (fetch_err),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h8C01_0004;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted instruction must match the oldest expected fetch.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver_unexpected actual=%h required=none", {fetch_err, instr_pc, instr_out});
            end else begin
                exp_item = exp_q.pop_front();
                if ({fetch_err, instr_pc, instr_out} !== exp_item) begin
                    errors++;
                    $display("FAIL deliver actual=%h required=%h", {fetch_err, instr_pc, instr_out}, exp_item);
                end
            end
        end
    end

    // mode: 0 delivered, 1 redirect while stalled, 2 redirect in completion cycle, 3 redirect in HOLD.
    task automatic run_txn(input logic [31:0] pc, input int waits, input int mode, input int hold, input bit b2b);
        logic [31:0] apc, word, hold_pc;
        bit          err_path;
        apc  = {pc[31:2], 2'b00};
        word = mem_word(apc);
`ifdef IFETCH_ALIGN_CHECK_EN
        err_path = (pc[1:0] != 2'b00);
`else
        err_path = 1'b0;
`endif
        hold_pc = err_path ? pc : apc;
        if (!chained) chk1("idle_stall", fetch_stall, 1'b0);
        pc_in = pc; pc_valid = 1'b1; avm_waitrequest = 1'b1; avm_readdata = word;
        step();
        chained = 1'b0; pc_valid = 1'b0; instr_ready = 1'b0; pc_in = pc + 32'd4;
        if (err_path) begin
            chk1("err_no_read", avm_read, 1'b0);
            chk1("err_valid", instr_valid, 1'b1);
            chk1("err_flag", fetch_err, 1'b1);
            chk32("err_pc", instr_pc, pc);
            chk32("err_instr", instr_out, 32'h0);
            if (mode != 3) exp_q.push_back({1'b1, pc, 32'h0});
        end else begin
            chk1("issue_read", avm_read, 1'b1);
            chk32("issue_addr", avm_address, apc);
            chk1("issue_stall", fetch_stall, 1'b1);
            chk1("issue_valid", instr_valid, 1'b0);
            for (int i = 0; i < waits; i++) begin
                redirect = (mode == 1) && (i == ((waits > 1) ? 1 : 0));
                step();
                redirect = 1'b0;
                chk1("wait_read", avm_read, 1'b1);
                chk32("wait_addr", avm_address, apc);
                chk1("wait_stall", fetch_stall, 1'b1);
            end
            avm_waitrequest = 1'b0; redirect = (mode == 2);
            step();
            avm_waitrequest = 1'b1; redirect = 1'b0;
            chk1("done_read", avm_read, 1'b0);
            if (mode == 1 || mode == 2) begin
                chk1("squash_valid", instr_valid, 1'b0);
                chk1("squash_stall", fetch_stall, 1'b0);
                return;
            end
            chk1("done_valid", instr_valid, 1'b1);
            chk32("done_pc", instr_pc, apc);
            chk32("done_instr", instr_out, word);
            chk1("done_err", fetch_err, 1'b0);
            if (mode == 0) exp_q.push_back({1'b0, apc, word});
        end
        for (int i = 0; i < hold; i++) begin
            step();
            chk1("hold_valid", instr_valid, 1'b1);
            chk1("hold_no_read", avm_read, 1'b0);
            chk32("hold_pc", instr_pc, hold_pc);
        end
        if (mode == 3) begin
            redirect = 1'b1; instr_ready = 1'($urandom_range(0, 1));
            step();
            redirect = 1'b0; instr_ready = 1'b0;
            chk1("redir_valid", instr_valid, 1'b0);
            chk1("redir_err", fetch_err, 1'b0);
            chk1("redir_stall", fetch_stall, 1'b0);
        end else begin
            instr_ready = 1'b1;
            if (b2b) begin
                chained = 1'b1;
            end else begin
                step();
                instr_ready = 1'b0;
                chk1("accept_valid", instr_valid, 1'b0);
                chk1("accept_err", fetch_err, 1'b0);
                chk1("accept_stall", fetch_stall, 1'b0);
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        int          rwaits, rmode, rhold;
        bit          rb2b;

        reset = 1'b1; pc_in = '0; pc_valid = 1'b0; redirect = 1'b0;
        avm_waitrequest = 1'b1; avm_readdata = '0; instr_ready = 1'b0;
        repeat (3) step();
        chk1("rst_read", avm_read, 1'b0);
        chk32("rst_addr", avm_address, 32'hBFC0_0000);
        chk32("rst_instr", instr_out, 32'h0);
        chk32("rst_pc", instr_pc, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_err", fetch_err, 1'b0);
        chk1("rst_stall", fetch_stall, 1'b0);
        chk32("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;

        run_txn(32'hBFC0_0000, 0, 0, 0, 1'b0);
        run_txn(32'hBFC0_0040, 3, 0, 1, 1'b0);
        run_txn(32'hBFC0_0080, 3, 1, 0, 1'b0);
        run_txn(32'hBFC0_0100, 0, 0, 0, 1'b0);
        run_txn(32'hBFC0_0200, 1, 0, 5, 1'b1);
        run_txn(32'hBFC0_0204, 0, 0, 0, 1'b0);
        run_txn(32'hBFC0_0002, 0, 0, 1, 1'b0);
        run_txn(32'hBFC0_0300, 2, 2, 0, 1'b0);
        run_txn(32'hBFC0_0304, 0, 3, 2, 1'b0);

        // Reset while a read is stalled on the bus.
        pc_in = 32'hBFC0_0400; pc_valid = 1'b1; avm_waitrequest = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk1("rst_req_read", avm_read, 1'b0);
        chk1("rst_req_valid", instr_valid, 1'b0);
        chk1("rst_req_stall", fetch_stall, 1'b0);
        chk32("rst_req_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        step();

        for (int n = 0; n < 60; n++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            rwaits = $urandom_range(0, 4);
            rmode  = $urandom_range(0, 3);
            if (rmode == 1 && rwaits == 0) rwaits = 1;
            rhold  = $urandom_range(0, 3);
            rb2b   = 1'($urandom_range(0, 1));
            run_txn(rpc, rwaits, rmode, rhold, rb2b);
        end
        if (chained) begin
            step();
            instr_ready = 1'b0;
            chained = 1'b0;
        end
        repeat (3) step();
        chk32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
